// File: rtl/pnode_rr_dispatch.sv
// pnode_rr_dispatch
//   Packet-atomic round-robin dispatcher. One ingress stream is shared among
//   NCOUNT pnodes. Each packet is locked to a single ready pnode from SOP to
//   EOP. Every grant issues an ordering tag {node id, sequence number}.
//
// Ports
//   clock, reset             rising-edge clock, async active-high reset
//   in_data/valid/sop/eop    ingress beat; in_ready is the ingress accept
//   node_data                ingress data broadcast to every pnode
//   node_valid[NCOUNT]       one-hot valid, only the locked node can be set
//   node_ready[NCOUNT]       per-pnode ready
//   tag_data/valid/ready     ordering tag {node id[3:0], seq[SEQW-1:0]}
//   drop_count               saturating count of non-SOP beats dropped in IDLE
//   busy                     high while a packet is locked (SEND)
module pnode_rr_dispatch #(
  parameter int unsigned NCOUNT = 8,
  parameter int unsigned DATAW  = 142,
  parameter int unsigned SEQW   = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATAW-1:0]  in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic [DATAW-1:0]  node_data,
  output logic [NCOUNT-1:0] node_valid,
  input  logic [NCOUNT-1:0] node_ready,
  output logic [SEQW+3:0]   tag_data,
  output logic              tag_valid,
  input  logic              tag_ready,
  output logic [15:0]       drop_count,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [3:0]      sel_q, sel_d;
  logic [3:0]      ptr_q, ptr_d;
  logic [SEQW-1:0] seq_q, seq_d;
  logic            tag_valid_q, tag_valid_d;
  logic [SEQW+3:0] tag_data_q, tag_data_d;
  logic [15:0]     drop_q, drop_d;

  // Node vectors widened to 16 bits so a 4-bit node id indexes them directly.
  logic [15:0]     ready_ext;
  logic [15:0]     nv_ext;
  logic [3:0]      cand;
  logic [3:0]      idx;
  logic            found;
  logic            tag_free;
  logic            in_ready_c;

  function automatic logic [3:0] wrap_inc(input logic [3:0] v);
    return ((32'(v) + 32'd1) >= NCOUNT) ? 4'd0 : v + 4'd1;
  endfunction

  assign ready_ext = 16'(node_ready);

  // First ready node at or after ptr, wrapping modulo NCOUNT.
  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx   = ptr_q;
    for (int unsigned k = 0; k < NCOUNT; k++) begin
      if (!found && ready_ext[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
      idx = wrap_inc(idx);
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    seq_d       = seq_q;
    tag_valid_d = tag_valid_q;
    tag_data_d  = tag_data_q;
    drop_d      = drop_q;
    nv_ext      = '0;
    in_ready_c  = 1'b0;
    // A tag accepted this cycle frees the slot for a grant in the same cycle.
    tag_free    = !tag_valid_q || tag_ready;
    if (tag_valid_q && tag_ready) tag_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && !in_sop) begin
          in_ready_c = 1'b1;
          if (drop_q != '1) drop_d = drop_q + 16'd1;
        end
        // The SOP beat is held here and transferred on the first SEND cycle.
        if (in_valid && in_sop && found && tag_free) begin
          state_d     = SEND;
          sel_d       = cand;
          tag_valid_d = 1'b1;
          tag_data_d  = {cand, seq_q};
          seq_d       = seq_q + SEQW'(1);
        end
      end
      SEND: begin
        nv_ext[sel_q] = in_valid;
        in_ready_c    = ready_ext[sel_q];
        if (in_valid && ready_ext[sel_q] && in_eop) begin
          state_d = IDLE;
          ptr_d   = wrap_inc(sel_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      seq_q       <= '0;
      tag_valid_q <= 1'b0;
      tag_data_q  <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      seq_q       <= seq_d;
      tag_valid_q <= tag_valid_d;
      tag_data_q  <= tag_data_d;
      drop_q      <= drop_d;
    end
  end

  // Reset gates the IDLE drop path, which would otherwise accept beats.
  assign in_ready   = in_ready_c & ~reset;
  assign node_valid = nv_ext[NCOUNT-1:0];
  assign node_data  = in_data;
  assign tag_data   = tag_data_q;
  assign tag_valid  = tag_valid_q;
  assign drop_count = drop_q;
  assign busy       = (state_q == SEND);

endmodule

// File: tb/tb_pnode_rr_dispatch.sv
module tb_pnode_rr_dispatch;
  localparam int unsigned NC = 8;
  localparam int unsigned DW = 142;
  localparam int unsigned SW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid, in_sop, in_eop, in_ready;
  logic [DW-1:0] node_data;
  logic [NC-1:0] node_valid, node_ready;
  logic [SW+3:0] tag_data;
  logic          tag_valid, tag_ready;
  logic [15:0]   drop_count;
  logic          busy;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [3:0]    node;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         beat_q[$];
  logic [SW+3:0] tag_q[$];
  int            node_beats[NC];
  int unsigned   data_ctr = 0;

  always #5 clock = ~clock;

  pnode_rr_dispatch #(.NCOUNT(NC), .DATAW(DW), .SEQW(SW)) dut (
    .clock(clock), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
    .in_ready(in_ready),
    .node_data(node_data), .node_valid(node_valid), .node_ready(node_ready),
    .tag_data(tag_data), .tag_valid(tag_valid), .tag_ready(tag_ready),
    .drop_count(drop_count), .busy(busy)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input int unsigned c);
    logic [DW-1:0] d;
    d           = '0;
    d[31:0]     = c;
    d[63:32]    = c * 32'h9E3779B1;
    d[DW-1 -: 32] = ~c;
    return d;
  endfunction

  // Scoreboard monitor: pops an expectation whenever the DUT hands off a tag or beat.
  beat_t         mb;
  logic [SW+3:0] mt;
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (tag_valid && tag_ready) begin
        if (tag_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL tag_unexpected: got %0h expected none", tag_data);
        end else begin
          mt = tag_q.pop_front();
          check("tag", tag_data, mt);
        end
      end
      if (node_valid != '0) begin
        check("nv_onehot", $countones(node_valid), 1);
        check("nv_busy", busy, 1);
      end
      for (int i = 0; i < NC; i++) begin
        if (node_valid[i] && node_ready[i]) begin
          node_beats[i]++;
          if (beat_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL beat_unexpected: got node %0d expected none", i);
          end else begin
            mb = beat_q.pop_front();
            check("beat_node", i, mb.node);
            check("beat_data", node_data, mb.data);
          end
        end
      end
    end
  end

  // Holds one beat until accepted; exp_cycles>0 checks the cycles it took.
  task automatic drive_beat(input logic sop, input logic eop, input logic [DW-1:0] d,
                            input int exp_cycles, input string name);
    int   n  = 0;
    logic ok = 1'b0;
    in_valid = 1'b1; in_sop = sop; in_eop = eop; in_data = d;
    while (!ok && n < 200) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (!ok) begin
      checks++; fails++;
      $display("FAIL %s_timeout: got no accept expected accept", name);
    end else if (exp_cycles > 0) begin
      check(name, n, exp_cycles);
    end
  endtask

  task automatic send_packet(input int node, input int seq, input int len, input int exp_sop);
    logic [DW-1:0] d;
    tag_q.push_back({4'(node), 10'(seq)});
    for (int b = 0; b < len; b++) begin
      d = mk_data(data_ctr);
      data_ctr++;
      beat_q.push_back('{node: 4'(node), data: d});
      drive_beat(b == 0, b == len - 1, d, (b == 0) ? exp_sop : 1,
                 (b == 0) ? "sop_latency" : "beat_wait");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int            k;
  logic [DW-1:0] dd;
  initial begin
    // Reset state, with a non-SOP beat offered so in_ready gating is visible.
    reset = 1'b1; in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_data = '0;
    node_ready = '1; tag_ready = 1'b1;
    for (int i = 0; i < NC; i++) node_beats[i] = 0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_node_valid", node_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_tag_valid", tag_valid, 0);
    check("rst_tag_data", tag_data, 0);
    check("rst_drop", drop_count, 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;

    // Five 90-beat packets, all nodes ready: nodes 0..4, tags {i,i}, 1-cycle bubble.
    for (int i = 0; i < 5; i++) send_packet(i, i, 90, 2);
    for (int i = 0; i < NC; i++) check("node_beat_count", node_beats[i], (i < 5) ? 90 : 0);

    // Sparse ready with ptr=3: node 5, node 2, node 5.
    do_reset();
    for (int i = 0; i < 3; i++) send_packet(i, i, 4, 2);
    node_ready = 8'b0010_0100;
    send_packet(5, 3, 4, 2);
    send_packet(2, 4, 4, 2);
    send_packet(5, 5, 4, 2);
    node_ready = '1;

    // Tag stall: tag_ready low for 50 cycles after the first grant.
    tag_ready = 1'b0;
    k = 0;
    fork
      begin
        send_packet(6, 6, 3, 2);
        send_packet(7, 7, 3, 49);
      end
      begin
        while (!tag_valid && k < 100) begin
          @(negedge clock);
          k++;
        end
        repeat (45) @(posedge clock);
        @(negedge clock);
        check("stall_in_ready", in_ready, 0);
        check("stall_node_valid", node_valid, 0);
        check("stall_busy", busy, 0);
        check("stall_sop_held", in_valid & in_sop, 1);
        repeat (5) @(posedge clock);
        #1 tag_ready = 1'b1;
      end
    join

    // 1030 single-beat packets: seq wraps 1023 -> 0 on packet 1025.
    do_reset();
    for (int i = 0; i < 1030; i++) send_packet(i % 8, i % 1024, 1, 2);

    // Three non-SOP beats in IDLE are dropped, then an intact packet (ptr=6, seq=6).
    for (int i = 0; i < 3; i++) begin
      dd = mk_data(32'hD000_0000 + 32'(i));
      drive_beat(1'b0, 1'b0, dd, 1, "drop_wait");
    end
    check("drop_count_3", drop_count, 3);
    send_packet(6, 6, 5, 2);

    // Reset at beat 40 of a packet locked to node 7 (ptr=7, seq=7).
    tag_q.push_back({4'd7, 10'd7});
    for (int b = 0; b < 40; b++) begin
      dd = mk_data(data_ctr);
      data_ctr++;
      beat_q.push_back('{node: 4'd7, data: dd});
      drive_beat(b == 0, 1'b0, dd, (b == 0) ? 2 : 1, (b == 0) ? "sop_latency" : "beat_wait");
    end
    reset = 1'b1; in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b0;
    in_data = mk_data(data_ctr);
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_node_valid", node_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tag_valid", tag_valid, 0);
    check("mid_rst_tag_data", tag_data, 0);
    check("mid_rst_drop", drop_count, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int b = 40; b < 60; b++) begin
      dd = mk_data(data_ctr);
      data_ctr++;
      drive_beat(1'b0, b == 59, dd, 1, "drop_wait");
    end
    check("drop_count_20", drop_count, 20);
    send_packet(0, 0, 6, 2);

    repeat (3) @(negedge clock);
    check("tag_queue_empty", tag_q.size(), 0);
    check("beat_queue_empty", beat_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
